// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-bank burst RAM controller.
package ram_pkg;

  localparam int unsigned DEPTH_LOG2_DEF = 3;
  localparam int unsigned RAM_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRdFill,
    StRdStream
  } state_e;

endpackage

// File: rtl/ram_addr_ctr.sv
// Loadable wrapping address counter; exposes current and incremented value.
module ram_addr_ctr #(
  parameter int unsigned AW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [AW-1:0] load_val_i,
  input  logic          inc_i,
  output logic [AW-1:0] cnt_o,
  output logic [AW-1:0] cnt_next_o
);

  logic [AW-1:0] cnt_q, cnt_d;

  // Natural AW-bit overflow gives the modulo 2**AW wrap.
  assign cnt_next_o = cnt_q + AW'(1);
  assign cnt_o      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_next_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_dual_burst_ctrl.sv
// Burst sequencer driving a synchronous dual-bank RAM with 1-cycle read latency.
module ram_dual_burst_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [DEPTH_LOG2-1:0] cmd_addr_a,
  input  logic [DEPTH_LOG2-1:0] cmd_addr_b,
  input  logic [DEPTH_LOG2-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WIDTH-1:0]      wr_data_a,
  input  logic [WIDTH-1:0]      wr_data_b,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data_a,
  output logic [WIDTH-1:0]      rd_data_b,
  output logic                  busy,
  output logic [DEPTH_LOG2-1:0] ram_addr_a,
  output logic [DEPTH_LOG2-1:0] ram_addr_b,
  output logic                  ram_we,
  output logic [WIDTH-1:0]      ram_din_a,
  output logic [WIDTH-1:0]      ram_din_b,
  input  logic [WIDTH-1:0]      ram_dout_a,
  input  logic [WIDTH-1:0]      ram_dout_b
);

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] beat_q, beat_d;
  logic                  ctr_load, ctr_inc, addr_use_next;
  logic [DEPTH_LOG2-1:0] cnt_a, cnt_a_next, cnt_b, cnt_b_next;

  ram_addr_ctr #(
    .AW (DEPTH_LOG2)
  ) u_ctr_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (ctr_load),
    .load_val_i (cmd_addr_a),
    .inc_i      (ctr_inc),
    .cnt_o      (cnt_a),
    .cnt_next_o (cnt_a_next)
  );

  ram_addr_ctr #(
    .AW (DEPTH_LOG2)
  ) u_ctr_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (ctr_load),
    .load_val_i (cmd_addr_b),
    .inc_i      (ctr_inc),
    .cnt_o      (cnt_b),
    .cnt_next_o (cnt_b_next)
  );

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    cmd_ready     = 1'b0;
    wr_ready      = 1'b0;
    rd_valid      = 1'b0;
    ram_we        = 1'b0;
    busy          = 1'b1;
    ctr_load      = 1'b0;
    ctr_inc       = 1'b0;
    addr_use_next = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          ctr_load = 1'b1;
          beat_d   = cmd_len;
          state_d  = cmd_wr ? StWr : StRdFill;
        end
      end
      StWr: begin
        wr_ready = 1'b1;
        ram_we   = wr_valid;
        if (wr_valid) begin
          ctr_inc = 1'b1;
          if (beat_q == '0) begin
            state_d = StIdle;
          end else begin
            beat_d = beat_q - DEPTH_LOG2'(1);
          end
        end
      end
      StRdFill: begin
        state_d = StRdStream;
      end
      StRdStream: begin
        rd_valid = 1'b1;
        // Present the next address on a handshake so data streams 1 beat/cycle.
        if (rd_ready) begin
          ctr_inc       = 1'b1;
          addr_use_next = 1'b1;
          if (beat_q == '0) begin
            state_d = StIdle;
          end else begin
            beat_d = beat_q - DEPTH_LOG2'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A reset arriving mid-burst must not commit the beat on offer.
    if (rst) begin
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  assign ram_addr_a = addr_use_next ? cnt_a_next : cnt_a;
  assign ram_addr_b = addr_use_next ? cnt_b_next : cnt_b;
  assign ram_din_a  = wr_data_a;
  assign ram_din_b  = wr_data_b;
  assign rd_data_a  = ram_dout_a;
  assign rd_data_b  = ram_dout_b;

endmodule

// File: doc/ram_dual_burst_ctrl.md
Name: ram_dual_burst_ctrl

Overview:
- Initiator/sequencer that drives the RAM side of the team's synchronous dual-bank 2x8 RAM: ram_addr_a/b, ram_we, ram_din_a/b out; ram_dout_a/b in, registered, 1-cycle read latency.
- Accepts burst commands (write or read, start address per bank, length 1..8 beats) over a valid/ready handshake.
- Streams write data in and read data out with valid/ready.
- Sits between a client datapath and the RAM.

Parameters:
- WIDTH, 8, data width per bank; must match the RAM instance.
- DEPTH_LOG2, 3, address width per bank; burst length and address wrap are modulo 2**DEPTH_LOG2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_wr  in  1  1 = write burst, 0 = read burst.
- cmd_addr_a  in  DEPTH_LOG2  bank A start address.
- cmd_addr_b  in  DEPTH_LOG2  bank B start address.
- cmd_len  in  DEPTH_LOG2  beats minus 1 (0 means 1 beat, 7 means 8 beats).
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  high in WR state.
- wr_data_a  in  WIDTH  bank A write data.
- wr_data_b  in  WIDTH  bank B write data.
- rd_valid  out  1  read beat available.
- rd_ready  in  1  consumer accepts read beat.
- rd_data_a  out  WIDTH  equals ram_dout_a.
- rd_data_b  out  WIDTH  equals ram_dout_b.
- busy  out  1  high when state is not IDLE.
- ram_addr_a  out  DEPTH_LOG2  RAM bank A address.
- ram_addr_b  out  DEPTH_LOG2  RAM bank B address.
- ram_we  out  1  RAM write enable.
- ram_din_a  out  WIDTH  equals wr_data_a.
- ram_din_b  out  WIDTH  equals wr_data_b.
- ram_dout_a  in  WIDTH  RAM bank A read data.
- ram_dout_b  in  WIDTH  RAM bank B read data.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; address counters and beat counter = 0.
  - rd_valid=0, busy=0, ram_we=0, cmd_ready=1 from the next cycle.
  - rst mid-burst aborts the burst; no partial completion; the next beat is not written.
- States: IDLE, WR, RD_FILL, RD_STREAM.
- IDLE:
  - On cmd_valid and cmd_ready: latch addr_a, addr_b and beat counter from cmd_len.
  - Go to WR if cmd_wr=1, else RD_FILL.
  - No other command is accepted until the state returns to IDLE.
- WR:
  - wr_ready=1; ram_we = wr_valid (combinational).
  - ram_addr_a/b come from the registered counters.
  - On each accepted beat, both counters increment modulo 2**DEPTH_LOG2 (7 wraps to 0) and the beat counter decrements.
  - Beat with counter=0 accepted: go to IDLE next cycle.
  - wr_valid=0 inserts bubbles; ram_we stays 0 during bubbles.
- RD_FILL:
  - Lasts one cycle; ram_we=0.
  - ram_addr holds the start address so the RAM captures it; rd_valid=0.
  - Go to RD_STREAM.
- RD_STREAM:
  - rd_valid=1; rd_data equals ram_dout (data for the current counters).
  - ram_addr_x = (rd_valid and rd_ready) ? counter_x+1 : counter_x, combinational, so the next beat arrives the following cycle: 1 beat/cycle throughput.
  - On a stall (rd_ready=0) the address is held and ram_we=0, so ram_dout is re-read and stays stable.
  - Last-beat handshake: go to IDLE, rd_valid=0 next cycle.
- Latency: read command accepted at cycle t; first rd_valid at t+2. Write beat k is in RAM at the edge where it is accepted.
- ram_we is never 1 outside WR; the WIDTH-bit datapath passes through unmodified.
- Back-to-back: a new command can be accepted the cycle after the last beat; minimum 1 IDLE cycle between bursts.
- cmd fields are ignored when cmd_valid=0 or when not in IDLE.

Decomposition:
- Shared package ram_pkg:
  - state enum (IDLE, WR, RD_FILL, RD_STREAM);
  - DEPTH_LOG2 default;
  - RAM_RD_LATENCY=1.
- One natural sub-module: ram_addr_ctr.
  - Loadable, wrapping DEPTH_LOG2 counter with inc-enable.
  - Exposes both the current and the next value (next is used for the combinational read address).
  - Instantiated twice, once per bank.
- Beat counter and FSM stay in the top module.

Test Plan:
- Reset then write burst: cmd_wr=1, addr_a=6, addr_b=0, len=3; data pairs (A0,10), (A1,11), (A2,12), (A3,13) with wr_valid constant.
  - Required: ram_we high for 4 cycles; ram_addr_a sequence 6, 7, 0, 1; ram_addr_b sequence 0, 1, 2, 3; then IDLE, cmd_ready=1.
- Read back the same burst with rd_ready=1:
  - Required: rd_valid first at t+2; rd_data_a = A0, A1, A2, A3 and rd_data_b = 10, 11, 12, 13 on 4 consecutive cycles.
- Read with rd_ready=0 for 3 cycles on beat 2:
  - Required: rd_valid held, rd_data stable at the beat 2 value, ram_addr held, ram_we=0; resumes without loss or duplication.
- Write with wr_valid bubbles (1, 0, 0, 1, 1, 0, 1) for len=3:
  - Required: exactly 4 RAM writes, ram_we=0 on bubble cycles, burst ends after the 4th accepted beat.
- Max length len=7 from addr 5:
  - Required: addresses wrap 5..7, 0..4; 8 beats; single-beat len=0 also completes correctly.
- Assert rst in the middle of a write burst (after beat 2 of 4):
  - Required: ram_we=0 from the next cycle, state IDLE, busy=0.
  - A readback confirms only beats 0..1 were written.
